// File: rtl/jump_redirect_ctrl_if.sv
// jump_redirect_ctrl_if
// Groups the ID-stage decode flags, EX/MEM destination info and the
// redirect/stall strobes exchanged with jump_redirect_ctrl.
//   master : the pipeline side (drives i_*, observes o_*)
//   slave  : the redirect controller (observes i_*, drives o_*)
interface jump_redirect_ctrl_if #(
  parameter int NB_REG = 5
);
  logic              i_enable;
  logic              i_valid_id;
  logic              i_jump;
  logic              i_jal;
  logic              i_jr;
  logic              i_jalr;
  logic [NB_REG-1:0] i_rs_id;
  logic [NB_REG-1:0] i_rd_id;
  logic              i_ex_regwrite;
  logic              i_ex_memread;
  logic [NB_REG-1:0] i_ex_rd;
  logic              i_mem_regwrite;
  logic              i_mem_memread;
  logic [NB_REG-1:0] i_mem_rd;
  logic              i_flush_ex;
  logic              o_stall_pc;
  logic              o_stall_ifid;
  logic              o_bubble_idex;
  logic              o_flush_ifid;
  logic [1:0]        o_pc_sel;
  logic              o_link_write;
  logic [NB_REG-1:0] o_link_reg;
  logic              o_busy;

  modport master (
    output i_enable, i_valid_id, i_jump, i_jal, i_jr, i_jalr, i_rs_id, i_rd_id,
           i_ex_regwrite, i_ex_memread, i_ex_rd,
           i_mem_regwrite, i_mem_memread, i_mem_rd, i_flush_ex,
    input  o_stall_pc, o_stall_ifid, o_bubble_idex, o_flush_ifid,
           o_pc_sel, o_link_write, o_link_reg, o_busy
  );

  modport slave (
    input  i_enable, i_valid_id, i_jump, i_jal, i_jr, i_jalr, i_rs_id, i_rd_id,
           i_ex_regwrite, i_ex_memread, i_ex_rd,
           i_mem_regwrite, i_mem_memread, i_mem_rd, i_flush_ex,
    output o_stall_pc, o_stall_ifid, o_bubble_idex, o_flush_ifid,
           o_pc_sel, o_link_write, o_link_reg, o_busy
  );
endinterface

// File: rtl/jump_redirect_ctrl.sv
// jump_redirect_ctrl
// Sequences J/JAL/JR/JALR redirects resolved in ID. Immediate jumps and
// hazard-free register jumps redirect in the detection cycle (Mealy in
// IDLE). A register jump whose rs is still being produced in EX/MEM holds
// fetch and bubbles ID/EX for N cycles, then redirects from GO.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   bus (slave)    : decode flags, EX/MEM destinations, i_enable, i_flush_ex
//                    in; stall/bubble/flush, pc_sel, link strobe, busy out
module jump_redirect_ctrl #(
  parameter int NB_REG          = 5,
  parameter int LINK_REG        = 31,
  parameter int EX_LOAD_STALLS  = 2,
  parameter int EX_ALU_STALLS   = 1,
  parameter int MEM_LOAD_STALLS = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  jump_redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    STALL = 2'b01,
    GO    = 2'b10
  } state_e;

  localparam logic [1:0]        EX_LOAD_N  = EX_LOAD_STALLS[1:0];
  localparam logic [1:0]        EX_ALU_N   = EX_ALU_STALLS[1:0];
  localparam logic [1:0]        MEM_LOAD_N = MEM_LOAD_STALLS[1:0];
  localparam logic [NB_REG-1:0] LINK_REG_V = LINK_REG[NB_REG-1:0];
  localparam logic [NB_REG-1:0] REG_ZERO   = {NB_REG{1'b0}};

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_IMM = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;

  function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
    max2 = (a > b) ? a : b;
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        need_s;
  logic              stall_s;
  logic              flush_ifid_s;
  logic [1:0]        pc_sel_s;
  logic              link_write_s;
  logic [NB_REG-1:0] link_reg_s;
  logic              out_en_s;

  // Stall requirement of the ID register jump: worst case over producers of rs.
  // r0 is never a hazard; a non-load in MEM is covered by forwarding.
  always_comb begin
    need_s = 2'b00;
    if (bus.i_rs_id != REG_ZERO) begin
      if (bus.i_ex_regwrite && bus.i_ex_memread && (bus.i_ex_rd == bus.i_rs_id)) begin
        need_s = max2(need_s, EX_LOAD_N);
      end else if (bus.i_ex_regwrite && !bus.i_ex_memread && (bus.i_ex_rd == bus.i_rs_id)) begin
        need_s = max2(need_s, EX_ALU_N);
      end else begin
        need_s = need_s;
      end
      if (bus.i_mem_regwrite && bus.i_mem_memread && (bus.i_mem_rd == bus.i_rs_id)) begin
        need_s = max2(need_s, MEM_LOAD_N);
      end else begin
        need_s = need_s;
      end
    end else begin
      need_s = 2'b00;
    end
  end

  // Next-state, counter and raw (ungated) output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_s      = 1'b0;
    flush_ifid_s = 1'b0;
    pc_sel_s     = PC_SEQ;
    link_write_s = 1'b0;
    link_reg_s   = REG_ZERO;
    if (!bus.i_enable) begin
      // Debug halt: freeze everything.
      state_d = state_q;
      cnt_d   = cnt_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid_id && bus.i_jr) begin
            if (need_s == 2'b00) begin
              pc_sel_s     = PC_REG;
              flush_ifid_s = 1'b1;
              link_write_s = bus.i_jalr && (bus.i_rd_id != REG_ZERO);
              link_reg_s   = bus.i_jalr ? bus.i_rd_id : REG_ZERO;
            end else begin
              // Detection cycle is itself the first bubble.
              stall_s = 1'b1;
              cnt_d   = need_s - 2'b01;
              state_d = (need_s > 2'b01) ? STALL : GO;
            end
          end else if (bus.i_valid_id && bus.i_jump) begin
            pc_sel_s     = PC_IMM;
            flush_ifid_s = 1'b1;
            link_write_s = bus.i_jal;
            link_reg_s   = bus.i_jal ? LINK_REG_V : REG_ZERO;
          end else begin
            state_d = IDLE;
          end
        end
        STALL: begin
          if (bus.i_flush_ex) begin
            // Jump was on a squashed path; let the branch redirect proceed.
            state_d = IDLE;
            cnt_d   = 2'b00;
          end else begin
            stall_s = 1'b1;
            cnt_d   = cnt_q - 2'b01;
            state_d = (cnt_q == 2'b01) ? GO : STALL;
          end
        end
        GO: begin
          state_d = IDLE;
          cnt_d   = 2'b00;
          if (bus.i_flush_ex) begin
            pc_sel_s = PC_SEQ;
          end else begin
            pc_sel_s     = PC_REG;
            flush_ifid_s = 1'b1;
            link_write_s = bus.i_jalr && (bus.i_rd_id != REG_ZERO);
            link_reg_s   = bus.i_jalr ? bus.i_rd_id : REG_ZERO;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 2'b00;
        end
      endcase
    end
  end

  // Outputs are forced low during reset and while the pipeline is halted.
  always_comb begin
    out_en_s = bus.i_enable && !i_reset;
    if (out_en_s) begin
      bus.o_stall_pc    = stall_s;
      bus.o_stall_ifid  = stall_s;
      bus.o_bubble_idex = stall_s;
      bus.o_flush_ifid  = flush_ifid_s;
      bus.o_pc_sel      = pc_sel_s;
      bus.o_link_write  = link_write_s;
      bus.o_link_reg    = link_reg_s;
      bus.o_busy        = (state_q != IDLE);
    end else begin
      bus.o_stall_pc    = 1'b0;
      bus.o_stall_ifid  = 1'b0;
      bus.o_bubble_idex = 1'b0;
      bus.o_flush_ifid  = 1'b0;
      bus.o_pc_sel      = PC_SEQ;
      bus.o_link_write  = 1'b0;
      bus.o_link_reg    = REG_ZERO;
      bus.o_busy        = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
module tb_jump_redirect_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  jump_redirect_ctrl_if #(.NB_REG(5)) bus ();

  jump_redirect_ctrl #(
    .NB_REG(5), .LINK_REG(31), .EX_LOAD_STALLS(2), .EX_ALU_STALLS(1), .MEM_LOAD_STALLS(1)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.i_enable       = 1'b1;
    bus.i_valid_id     = 1'b0;
    bus.i_jump         = 1'b0;
    bus.i_jal          = 1'b0;
    bus.i_jr           = 1'b0;
    bus.i_jalr         = 1'b0;
    bus.i_rs_id        = 5'd0;
    bus.i_rd_id        = 5'd0;
    bus.i_ex_regwrite  = 1'b0;
    bus.i_ex_memread   = 1'b0;
    bus.i_ex_rd        = 5'd0;
    bus.i_mem_regwrite = 1'b0;
    bus.i_mem_memread  = 1'b0;
    bus.i_mem_rd       = 5'd0;
    bus.i_flush_ex     = 1'b0;
  endtask

  // Advance to the next falling edge; inputs set after it, checks #1 later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Checks stall/redirect group together: {stall_pc,stall_ifid,bubble,flush,pc_sel,link_write,busy}
  task automatic check_outs(input string tag, input logic stall, input logic flush,
                            input logic [1:0] sel, input logic lw, input logic busy);
    #1;
    check_val({tag, ".stall_pc"},   {31'd0, bus.o_stall_pc},    {31'd0, stall});
    check_val({tag, ".stall_ifid"}, {31'd0, bus.o_stall_ifid},  {31'd0, stall});
    check_val({tag, ".bubble"},     {31'd0, bus.o_bubble_idex}, {31'd0, stall});
    check_val({tag, ".flush_ifid"}, {31'd0, bus.o_flush_ifid},  {31'd0, flush});
    check_val({tag, ".pc_sel"},     {30'd0, bus.o_pc_sel},      {30'd0, sel});
    check_val({tag, ".link_write"}, {31'd0, bus.o_link_write},  {31'd0, lw});
    check_val({tag, ".busy"},       {31'd0, bus.o_busy},        {31'd0, busy});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    rst = 1'b1;

    // Reset state
    next_cycle();
    check_outs("reset", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    check_val("reset.link_reg", {27'd0, bus.o_link_reg}, 32'd0);
    rst = 1'b0;

    // JR rs=5, no producer: immediate register redirect
    next_cycle();
    bus.i_valid_id = 1'b1; bus.i_jr = 1'b1; bus.i_rs_id = 5'd5;
    check_outs("jr_nohaz", 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    next_cycle();
    clear_inputs();
    check_outs("jr_nohaz.after", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // JAL: immediate redirect with link to r31
    next_cycle();
    bus.i_valid_id = 1'b1; bus.i_jump = 1'b1; bus.i_jal = 1'b1;
    check_outs("jal", 1'b0, 1'b1, 2'b01, 1'b1, 1'b0);
    check_val("jal.link_reg", {27'd0, bus.o_link_reg}, 32'd31);

    // JALR rs=8 rd=9, EX load writes r8: 2 stall cycles then GO
    next_cycle();
    clear_inputs();
    bus.i_valid_id = 1'b1; bus.i_jr = 1'b1; bus.i_jalr = 1'b1;
    bus.i_rs_id = 5'd8; bus.i_rd_id = 5'd9;
    bus.i_ex_regwrite = 1'b1; bus.i_ex_memread = 1'b1; bus.i_ex_rd = 5'd8;
    check_outs("jalr_exld.c0", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    next_cycle();
    bus.i_ex_regwrite = 1'b0; bus.i_ex_memread = 1'b0; bus.i_ex_rd = 5'd0;
    check_outs("jalr_exld.c1", 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    next_cycle();
    check_outs("jalr_exld.go", 1'b0, 1'b1, 2'b10, 1'b1, 1'b1);
    check_val("jalr_exld.link_reg", {27'd0, bus.o_link_reg}, 32'd9);
    next_cycle();
    clear_inputs();
    check_outs("jalr_exld.idle", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // JR rs=3, EX ALU and MEM load both write r3: max is 1 stall
    next_cycle();
    bus.i_valid_id = 1'b1; bus.i_jr = 1'b1; bus.i_rs_id = 5'd3;
    bus.i_ex_regwrite = 1'b1; bus.i_ex_rd = 5'd3;
    bus.i_mem_regwrite = 1'b1; bus.i_mem_memread = 1'b1; bus.i_mem_rd = 5'd3;
    check_outs("jr_max1.c0", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    next_cycle();
    bus.i_ex_regwrite = 1'b0; bus.i_ex_rd = 5'd0;
    bus.i_mem_regwrite = 1'b0; bus.i_mem_memread = 1'b0; bus.i_mem_rd = 5'd0;
    check_outs("jr_max1.go", 1'b0, 1'b1, 2'b10, 1'b0, 1'b1);

    // JR rs=0 with EX load to r0: never a hazard
    next_cycle();
    clear_inputs();
    bus.i_valid_id = 1'b1; bus.i_jr = 1'b1; bus.i_rs_id = 5'd0;
    bus.i_ex_regwrite = 1'b1; bus.i_ex_memread = 1'b1; bus.i_ex_rd = 5'd0;
    check_outs("jr_r0", 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);

    // EX load hazard, enable low 3 cycles mid-STALL
    next_cycle();
    clear_inputs();
    bus.i_valid_id = 1'b1; bus.i_jr = 1'b1; bus.i_rs_id = 5'd4;
    bus.i_ex_regwrite = 1'b1; bus.i_ex_memread = 1'b1; bus.i_ex_rd = 5'd4;
    check_outs("halt.c0", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      bus.i_ex_regwrite = 1'b0; bus.i_ex_memread = 1'b0; bus.i_ex_rd = 5'd0;
      bus.i_enable = 1'b0;
      check_outs($sformatf("halt.frozen%0d", i), 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    end
    next_cycle();
    bus.i_enable = 1'b1;
    check_outs("halt.resume_stall", 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    next_cycle();
    check_outs("halt.go", 1'b0, 1'b1, 2'b10, 1'b0, 1'b1);

    // Flush from EX while in STALL: abort, no register redirect
    next_cycle();
    clear_inputs();
    bus.i_valid_id = 1'b1; bus.i_jr = 1'b1; bus.i_rs_id = 5'd6;
    bus.i_ex_regwrite = 1'b1; bus.i_ex_memread = 1'b1; bus.i_ex_rd = 5'd6;
    check_outs("flush.c0", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    next_cycle();
    bus.i_ex_regwrite = 1'b0; bus.i_ex_memread = 1'b0; bus.i_ex_rd = 5'd0;
    bus.i_flush_ex = 1'b1;
    #1;
    check_val("flush.stall.pc_sel", {30'd0, bus.o_pc_sel}, 32'd0);
    check_val("flush.stall.busy", {31'd0, bus.o_busy}, 32'd1);
    next_cycle();
    clear_inputs();
    check_outs("flush.idle", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    next_cycle();
    check_outs("flush.idle2", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // Reset asserted in GO: outputs drop immediately
    bus.i_valid_id = 1'b1; bus.i_jr = 1'b1; bus.i_jalr = 1'b1;
    bus.i_rs_id = 5'd7; bus.i_rd_id = 5'd12;
    bus.i_ex_regwrite = 1'b1; bus.i_ex_rd = 5'd7;
    check_outs("rstgo.c0", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    next_cycle();
    bus.i_ex_regwrite = 1'b0; bus.i_ex_rd = 5'd0;
    check_outs("rstgo.go", 1'b0, 1'b1, 2'b10, 1'b1, 1'b1);
    check_val("rstgo.link_reg", {27'd0, bus.o_link_reg}, 32'd12);
    rst = 1'b1;
    check_outs("rstgo.inreset", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    check_outs("rstgo.idle", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
